// File: rtl/mod6_stream_if.sv
// Bundle of the count-stream inputs and the checker's status outputs.
// The master side drives samples and clear. The slave side is the checker.
interface mod6_stream_if #(
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
);
  logic              sample_valid;
  logic [2:0]        sample;
  logic              clear;
  logic              locked;
  logic              err_pulse;
  logic [2:0]        expected;
  logic [ERR_W-1:0]  err_count;
  logic [WRAP_W-1:0] wrap_count;

  modport master (
    output sample_valid, sample, clear,
    input  locked, err_pulse, expected, err_count, wrap_count
  );

  modport slave (
    input  sample_valid, sample, clear,
    output locked, err_pulse, expected, err_count, wrap_count
  );
endinterface

// File: rtl/mod6_stream_checker.sv
// Lock/predict/flag checker for a mod-MOD count stream, with saturating error and wrap tallies.
// Optional MOD6_CHK_HOLD_EN: a repeat of the previous sample is accepted as a source stall.
module mod6_stream_checker #(
  parameter int MOD         = 6,
  parameter int LOCK_RUN    = 3,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 8
) (
  input logic          clk,
  input logic          rst,
  mod6_stream_if.slave chk
);
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [2:0] LAST   = 3'(MOD - 1);
  localparam logic [3:0] MOD_L  = 4'(MOD);
  localparam logic [2:0] RUN_L  = 3'(LOCK_RUN);
  localparam logic [2:0] MISS_L = 3'(UNLOCK_ERRS);

  state_e            state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic [2:0]        run_q, run_d;
  logic [2:0]        miss_q, miss_d;
  logic [2:0]        exp_q, exp_d;
  logic              pulse_q, pulse_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  logic       legal, hold, err_hit, wrap_hit;
  logic [2:0] prev_succ, samp_succ, run_inc, miss_inc;

  // Explicit compare against the last legal value keeps non-power-of-two moduli cheap.
  function automatic logic [2:0] succ(input logic [2:0] v);
    return (v == LAST) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [WRAP_W-1:0] sat_wrap(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign legal     = ({1'b0, chk.sample} < MOD_L);
  assign prev_succ = succ(prev_q);
  assign samp_succ = succ(chk.sample);
  assign run_inc   = run_q + 3'd1;
  assign miss_inc  = miss_q + 3'd1;

`ifdef MOD6_CHK_HOLD_EN
  assign hold = (chk.sample == prev_q);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_d    = run_q;
    miss_d   = miss_q;
    exp_d    = exp_q;
    pulse_d  = 1'b0;
    err_hit  = 1'b0;
    wrap_hit = 1'b0;
    if (chk.sample_valid) begin
      unique case (state_q)
        HUNT: begin
          if (legal) begin
            prev_d  = chk.sample;
            run_d   = 3'd0;
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (!legal) begin
            state_d = HUNT;
          end else if (!hold) begin
            prev_d = chk.sample;
            if (chk.sample == prev_succ) begin
              run_d = run_inc;
              if (run_inc == RUN_L) begin
                state_d = LOCKED;
                exp_d   = samp_succ;
                miss_d  = 3'd0;
              end
            end else begin
              run_d = 3'd0;
            end
          end
        end
        LOCKED: begin
          if (chk.sample == exp_q) begin
            miss_d   = 3'd0;
            exp_d    = samp_succ;
            prev_d   = chk.sample;
            wrap_hit = (chk.sample == 3'd0);
          end else if (!hold) begin
            pulse_d = 1'b1;
            err_hit = 1'b1;
            miss_d  = miss_inc;
            // An illegal value gives nothing to resync on, so the prediction holds.
            if (legal) begin
              exp_d  = samp_succ;
              prev_d = chk.sample;
            end
            if (miss_inc == MISS_L) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    err_d  = chk.clear ? '0 : (err_hit  ? sat_err(err_q)   : err_q);
    wrap_d = chk.clear ? '0 : (wrap_hit ? sat_wrap(wrap_q) : wrap_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      prev_q  <= 3'd0;
      run_q   <= 3'd0;
      miss_q  <= 3'd0;
      exp_q   <= 3'd0;
      pulse_q <= 1'b0;
      err_q   <= '0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      exp_q   <= exp_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign chk.locked     = (state_q == LOCKED);
  assign chk.err_pulse  = pulse_q;
  assign chk.expected   = exp_q;
  assign chk.err_count  = err_q;
  assign chk.wrap_count = wrap_q;
endmodule
